// File: rtl/resp_cap_pkg.sv
// resp_cap_pkg
//   Shared definitions for the response capture block: FSM state encoding,
//   default parameter values and the output-width helper.
//   Optional feature macro: RESP_CAP_TIMESTAMP_EN
//     defined   -> each buffered entry carries a TS_W-bit capture timestamp
//     undefined -> entries hold the sample only
package resp_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_DEPTH  = 100;
    localparam int DEF_TS_W   = 16;

    // Width of one buffered entry / rd_data.
    function automatic int out_w(input int data_w, input int ts_w);
`ifdef RESP_CAP_TIMESTAMP_EN
        return data_w + ts_w;
`else
        // ts_w has no effect without timestamps.
        return (ts_w >= 0) ? data_w : data_w;
`endif
    endfunction

endpackage

// File: rtl/resp_cap_mem.sv
// resp_cap_mem
//   Simple dual-port RAM, DEPTH x WIDTH: one write port, one synchronous read
//   port with read enable. rdata holds its value while re is low, which lets
//   the drain pipeline stall without re-reading.
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (rdata updates on the next rising edge)
//   raddr  in   read address
//   rdata  out  registered read data
module resp_cap_mem #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 100,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/response_capture.sv
// response_capture
//   Records response vectors into an on-chip buffer during a capture window,
//   then drains them in order over a valid/ready stream.
//   Optional feature macro: RESP_CAP_TIMESTAMP_EN (per-entry capture timestamp,
//   rd_data = {ts, sample}); default build stores the sample only.
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   pulse: clear buffer, enter CAPTURE (honoured in IDLE only)
//   stop          in   pulse: end CAPTURE, enter DRAIN
//   sample_valid  in   sample_data is captured this cycle
//   sample_data   in   response vector, DATA_W bits
//   rd_valid      out  rd_data holds a buffered entry
//   rd_ready      in   consumer accepts entry
//   rd_data       out  buffered entry, OUT_W bits
//   rd_last       out  rd_data is the final entry of the drain
//   busy          out  state != IDLE
//   full          out  count == DEPTH
//   count         out  entries captured, held through DRAIN
//   overflow      out  sticky: a sample arrived while full
//   dbg_state     out  current FSM state (resp_cap_pkg::state_t encoding)
// Handshake: an entry transfers on every rising edge where rd_valid and
//   rd_ready are both high; once rd_valid is high, rd_data and rd_last hold
//   until that transfer happens.
module response_capture
    import resp_cap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TS_W   = DEF_TS_W,
    localparam int OUT_W = out_w(DATA_W, TS_W),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t           state;
    logic [CW-1:0]    rd_ptr;     // next buffer address to read
    logic             s1_valid;   // RAM output register holds an unconsumed entry
    logic             s1_last;    // that entry is the final one
    logic [OUT_W-1:0] mem_q;
    logic [OUT_W-1:0] wdata;
    logic             wr_en;
    logic             issue_left;
    logic             take;
    logic             out_load;
    logic             rd_en;

`ifdef RESP_CAP_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
    assign wdata = {ts, sample_data};
`else
    assign wdata = sample_data;
`endif

    assign full      = (count == CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign wr_en = (state == CAPTURE) && sample_valid && !full;

    // Two-stage read pipeline: RAM output register (s1) feeding the rd_*
    // output register. s1 may refill in the same cycle it hands its entry to
    // the output, so a consumer holding rd_ready high sees one entry per cycle.
    assign issue_left = (state == DRAIN) && (rd_ptr < count);
    assign take       = rd_valid && rd_ready;
    assign out_load   = s1_valid && (!rd_valid || rd_ready);
    assign rd_en      = issue_left && (!s1_valid || out_load);

    resp_cap_mem #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[AW-1:0]),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
`ifdef RESP_CAP_TIMESTAMP_EN
            ts       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CAPTURE;
                        count    <= '0;
                        overflow <= 1'b0;
`ifdef RESP_CAP_TIMESTAMP_EN
                        ts       <= '0;
`endif
                    end
                end

                CAPTURE: begin
`ifdef RESP_CAP_TIMESTAMP_EN
                    ts <= ts + 1'b1;
`endif
                    if (wr_en) begin
                        count <= count + ONE;
                    end
                    // Samples arriving while full are dropped but remembered.
                    if (sample_valid && full) begin
                        overflow <= 1'b1;
                    end
                    if (stop) begin
                        rd_ptr   <= '0;
                        s1_valid <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        // Nothing captured (counting a same-cycle store): skip the drain.
                        if ((count == '0) && !wr_en) begin
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (rd_en) begin
                        rd_ptr  <= rd_ptr + ONE;
                        s1_last <= (rd_ptr == (count - ONE));
                    end

                    if (rd_en) begin
                        s1_valid <= 1'b1;
                    end else if (out_load) begin
                        s1_valid <= 1'b0;
                    end

                    if (out_load) begin
                        rd_data  <= mem_q;
                        rd_last  <= s1_last;
                        rd_valid <= 1'b1;
                    end else if (take) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end

                    if (take && rd_last) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_response_capture.sv
// tb_response_capture
//   Directed test of response_capture (DEPTH=5, TS_W=4) against a
//   transaction-level model: a queue of captured entries, a captured count,
//   a sticky overflow flag and a drain-start delay.
module tb_response_capture;
    import resp_cap_pkg::*;

    localparam int DATA_W = 5;
    localparam int DEPTH  = 5;
    localparam int TS_W   = 4;
`ifdef RESP_CAP_TIMESTAMP_EN
    localparam int OUT_W  = DATA_W + TS_W;
`else
    localparam int OUT_W  = DATA_W;
`endif
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_last;
    logic              busy;
    logic              full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [1:0]        dbg_state;

    response_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] mk(input int ts, input logic [DATA_W-1:0] d);
`ifdef RESP_CAP_TIMESTAMP_EN
        mk = {TS_W'(ts), d};
`else
        mk = d;
`endif
    endfunction

    // ---------------- model ----------------
    // m_mode: 0 idle, 1 capturing, 2 draining
    logic [OUT_W-1:0] exp_q[$];
    int m_mode  = 0;
    int m_count = 0;
    bit m_ov    = 1'b0;
    int m_ts    = 0;
    int m_age   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_count = 0; m_ov = 1'b0; m_ts = 0; m_age = 0;
            exp_q.delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_count = 0; m_ov = 1'b0; m_ts = 0;
                    exp_q.delete();
                end
                1: begin
                    if (sample_valid) begin
                        if (m_count < DEPTH) begin
                            exp_q.push_back(mk(m_ts, sample_data));
                            m_count++;
                        end else begin
                            m_ov = 1'b1;
                        end
                    end
                    m_ts = (m_ts + 1) % (1 << TS_W);
                    if (stop) begin
                        if (m_count == 0) m_mode = 0;
                        else begin
                            m_mode = 2;
                            m_age  = 0;
                        end
                    end
                end
                default: begin
                    // First entry is offered two cycles after the stop cycle.
                    if (m_age >= 2 && rd_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) m_mode = 0;
                    end
                    if (m_age < 2) m_age++;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_valid;
            logic [1:0] exp_state;
            exp_valid = (m_mode == 2) && (m_age >= 2);
            exp_state = (m_mode == 0) ? IDLE : (m_mode == 1) ? CAPTURE : DRAIN;
            check("busy", busy, m_mode != 0);
            check("state", dbg_state, exp_state);
            check("count", count, m_count);
            check("full", full, m_count == DEPTH);
            check("overflow", overflow, m_ov);
            check("rd_valid", rd_valid, exp_valid);
            if (exp_valid) begin
                check("rd_data", rd_data, exp_q[0]);
                check("rd_last", rd_last, exp_q.size() == 1);
            end
        end
    end

    // ---------------- drained-entry collector ----------------
    logic [OUT_W-1:0] got_q[$];
    int n_taken = 0;

    always @(negedge clk) begin
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            got_q.push_back(rd_data);
            n_taken++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_sample(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1; sample_data = d; cycle(); sample_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic do_stop_sample(input logic [DATA_W-1:0] d);
        stop = 1'b1; sample_valid = 1'b1; sample_data = d;
        cycle();
        stop = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        check({name, "_timeout"}, n < 200, 1);
    endtask

    logic [OUT_W-1:0] lit_q[$];

    task automatic check_got(input string name);
        check({name, "_n"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_e%0d", name, i), got_q[i], lit_q[i]);
        end
    endtask

    task automatic new_test();
        got_q.delete();
        lit_q.delete();
        n_taken = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
        sample_data = '0; rd_ready = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);

        // 1: basic capture/drain; sample in the start cycle is not stored.
        new_test();
        rd_ready = 1'b1;
        start = 1'b1; sample_valid = 1'b1; sample_data = 5'h11;
        cycle();
        start = 1'b0; sample_valid = 1'b0;
        do_sample(5'h01); do_sample(5'h0A); do_sample(5'h15); do_sample(5'h1F);
        do_stop();
        wait_idle("t1");
        lit_q.push_back(mk(0, 5'h01)); lit_q.push_back(mk(1, 5'h0A));
        lit_q.push_back(mk(2, 5'h15)); lit_q.push_back(mk(3, 5'h1F));
        check_got("t1");
        check("t1_count", count, 4);
        check("t1_busy", busy, 0);

        // 2: overflow at DEPTH=5 with 7 samples; start during CAPTURE ignored.
        new_test();
        do_start();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) start = 1'b1;
            do_sample(DATA_W'(i * 3 + 2));
            start = 1'b0;
        end
        check("t2_full", full, 1);
        check("t2_overflow", overflow, 1);
        check("t2_count_full", count, 5);
        do_stop();
        wait_idle("t2");
        for (int i = 0; i < 5; i++) lit_q.push_back(mk(i, DATA_W'(i * 3 + 2)));
        check_got("t2");
        check("t2_overflow_held", overflow, 1);

        // 3: stalled drain with rd_ready toggling; stop with a same-cycle sample.
        new_test();
        do_start();
        do_sample(5'h1E); do_sample(5'h00); do_sample(5'h15); do_sample(5'h0A);
        do_stop_sample(5'h1B);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            rd_ready = ~rd_ready;
            cycle();
            n++;
        end
        check("t3_timeout", n < 200, 1);
        rd_ready = 1'b1;
        lit_q.push_back(mk(0, 5'h1E)); lit_q.push_back(mk(1, 5'h00));
        lit_q.push_back(mk(2, 5'h15)); lit_q.push_back(mk(3, 5'h0A));
        lit_q.push_back(mk(4, 5'h1B));
        check_got("t3");
        check("t3_overflow_cleared", overflow, 0);

        // 4: empty capture goes straight back to IDLE.
        new_test();
        do_start();
        do_stop();
        check("t4_busy", busy, 0);
        idle(4);
        check("t4_no_output", got_q.size(), 0);
        check("t4_count", count, 0);

        // 4b: empty buffer but sample in the stop cycle -> one-entry drain.
        new_test();
        do_start();
        do_stop_sample(5'h07);
        wait_idle("t4b");
        lit_q.push_back(mk(0, 5'h07));
        check_got("t4b");

        // 5: reset mid-drain, then a fresh capture drains only new data.
        new_test();
        do_start();
        for (int i = 0; i < 5; i++) do_sample(DATA_W'(5'h10 + i));
        do_stop();
        n = 0;
        while (n_taken < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("t5_wait", n < 50, 1);
        rst = 1'b1; rd_ready = 1'b0;
        cycle();
        rst = 1'b0;
        check("t5_rd_valid", rd_valid, 0);
        check("t5_rd_last", rd_last, 0);
        check("t5_busy", busy, 0);
        check("t5_count", count, 0);
        new_test();
        rd_ready = 1'b1;
        do_start();
        do_sample(5'h03); do_sample(5'h0C); do_sample(5'h19);
        do_stop();
        wait_idle("t5");
        lit_q.push_back(mk(0, 5'h03)); lit_q.push_back(mk(1, 5'h0C));
        lit_q.push_back(mk(2, 5'h19));
        check_got("t5");

`ifdef RESP_CAP_TIMESTAMP_EN
        // 6: timestamps at cycles 0,3,7,17 after start; 17 wraps to 1 (TS_W=4).
        new_test();
        do_start();
        do_sample(5'h02); idle(2);
        do_sample(5'h04); idle(3);
        do_sample(5'h06); idle(9);
        do_sample(5'h08);
        do_stop();
        wait_idle("t6");
        lit_q.push_back({4'd0, 5'h02}); lit_q.push_back({4'd3, 5'h04});
        lit_q.push_back({4'd7, 5'h06}); lit_q.push_back({4'd1, 5'h08});
        check_got("t6");
`endif

        idle(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
